stream_mux_rr: RTL

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes, round-robin or fixed-priority arbitration, packet locking and a registered output stage. It generalises the 2:1 select mux into a channel combiner for the datapath: several producers feed one consumer, and the block chooses the source instead of taking an external select. Throughput is one beat per clock with one cycle of latency.

---
 rtl/stream_mux_rr.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream combiner with round-robin or
// fixed-priority arbitration, optional packet locking and a single registered
// output stage (one beat per clock, one cycle of latency, no skid buffer).
module stream_mux_rr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = 0,
  parameter int unsigned PACKET   = 1,
  localparam int unsigned SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
);

  // OPEN: arbitrate freely; LOCKED: only lock_ch may deliver until its last beat.
  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int unsigned LAST_CH = CHANNELS - 1;

  state_e            state_q, state_d;
  logic [SELW-1:0]   lock_ch_q, lock_ch_d;
  logic [SELW-1:0]   last_grant_q, last_grant_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [SELW-1:0]   out_sel_q, out_sel_d;

  logic              load_en;
  logic              grant_vld;
  logic [SELW-1:0]   grant_idx;
  logic              accept;
  logic [WIDTH-1:0]  grant_data;
  logic              grant_last;
  int unsigned       rr_cand;

  // Output register can take a new beat when empty or being drained this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Grant selection: locked channel only, else lowest index or rotating search.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_cand   = 0;
    if (state_q == ST_LOCKED) begin
      grant_idx = lock_ch_q;
      grant_vld = in_valid[lock_ch_q];
    end else if (MODE == 1) begin
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
        if (in_valid[SELW'(i)]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int unsigned i = 1; i <= CHANNELS; i++) begin
        rr_cand = int'(last_grant_q) + i;
        if (rr_cand >= CHANNELS) begin
          rr_cand = rr_cand - CHANNELS;
        end
        if (!grant_vld && in_valid[SELW'(rr_cand)]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(rr_cand);
        end
      end
    end
  end

  // Payload of the granted channel.
  always_comb begin
    grant_data = '0;
    grant_last = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
        grant_last = in_last[i];
      end
    end
  end

  assign accept = grant_vld && load_en && !rst;

  // One-hot ready towards the granted, valid channel only.
  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state: load on acceptance, otherwise drain; lock tracks packet boundaries.
  always_comb begin
    state_d      = state_q;
    lock_ch_d    = lock_ch_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_sel_d    = out_sel_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = grant_data;
      out_last_d   = grant_last;
      out_sel_d    = grant_idx;
      last_grant_d = grant_idx;
      if ((PACKET != 0) && !grant_last) begin
        state_d   = ST_LOCKED;
        lock_ch_d = grant_idx;
      end else begin
        state_d   = ST_OPEN;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset gives channel 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OPEN;
      lock_ch_q    <= '0;
      last_grant_q <= SELW'(LAST_CH);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      lock_ch_q    <= lock_ch_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_sel_q    <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule
